// File: rtl/sumhsq_result_capture_pkg.sv
// Shared register map, status bit positions and reset values for the
// sum-of-squares result capture port.
package sumhsq_result_capture_pkg;

    localparam int unsigned BUS_W = 32;

    localparam logic [1:0] ADDR_DATA     = 2'd0;
    localparam logic [1:0] ADDR_STATUS   = 2'd1;
    localparam logic [1:0] ADDR_IRQ_MASK = 2'd2;
    localparam logic [1:0] ADDR_COUNT    = 2'd3;

    localparam int unsigned NEW_BIT = 0;
    localparam int unsigned OVR_BIT = 1;

    localparam logic [1:0] STATUS_RST   = 2'b00;
    localparam logic [1:0] IRQ_MASK_RST = 2'b00;

endpackage

// File: rtl/sumhsq_capture_counter.sv
// Wrapping capture counter; a clear and an increment in the same cycle
// leave the count at 1 so the coincident capture is not lost.
module sumhsq_capture_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_d;

    // Next count: clear first, then apply the increment
    always_comb begin
        count_d = count;
        if (clear) begin
            count_d = '0;
        end
        if (inc) begin
            count_d = count_d + CNT_W'(1);
        end
    end

    // Count register with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else begin
            count <= count_d;
        end
    end

endmodule

// File: rtl/sumhsq_result_capture.sv
// Avalon-MM read port for the SUMHSQ result: holding register, sticky
// NEW/OVR flags, capture counter and optional interrupt.
// Optional feature macro: SUMHSQ_CAPTURE_IRQ_EN (IRQ_MASK register + irq).
module sumhsq_result_capture #(
    parameter int unsigned DATA_W = 24,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              irq
);

    import sumhsq_result_capture_pkg::*;

    logic              wr;
    logic              clr_new;
    logic              clr_ovr;
    logic              cnt_clear;
    logic [DATA_W-1:0] data_q;
    logic [1:0]        status_q;
    logic [1:0]        status_d;
    logic [CNT_W-1:0]  count;
    logic              unused_wdata;

    assign wr           = chipselect & ~write_n;
    assign clr_new      = wr && (address == ADDR_STATUS) && writedata[NEW_BIT];
    assign clr_ovr      = wr && (address == ADDR_STATUS) && writedata[OVR_BIT];
    assign cnt_clear    = wr && (address == ADDR_COUNT);
    assign unused_wdata = &{1'b0, writedata[31:2]};

    // Flag update: W1C is applied before the capture, and a capture sets
    // OVR only if NEW survives the clear
    always_comb begin
        status_d = status_q;
        if (clr_new) begin
            status_d[NEW_BIT] = 1'b0;
        end
        if (clr_ovr) begin
            status_d[OVR_BIT] = 1'b0;
        end
        if (in_valid) begin
            if (status_d[NEW_BIT]) begin
                status_d[OVR_BIT] = 1'b1;
            end
            status_d[NEW_BIT] = 1'b1;
        end
    end

    // Holding register and status flags
    always_ff @(posedge clk) begin
        if (reset) begin
            data_q   <= '0;
            status_q <= STATUS_RST;
        end else begin
            if (in_valid) begin
                data_q <= in_data;
            end
            status_q <= status_d;
        end
    end

    sumhsq_capture_counter #(
        .CNT_W (CNT_W)
    ) u_counter (
        .clk   (clk),
        .reset (reset),
        .clear (cnt_clear),
        .inc   (in_valid),
        .count (count)
    );

`ifdef SUMHSQ_CAPTURE_IRQ_EN
    logic [1:0] irq_mask_q;

    // Interrupt mask register
    always_ff @(posedge clk) begin
        if (reset) begin
            irq_mask_q <= IRQ_MASK_RST;
        end else if (wr && (address == ADDR_IRQ_MASK)) begin
            irq_mask_q <= writedata[1:0];
        end
    end

    assign irq = |(status_q & irq_mask_q);
`else
    assign irq = 1'b0;
`endif

    // Zero-wait-state read mux, unused bits read as 0
    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA:     readdata = BUS_W'(data_q);
            ADDR_STATUS:   readdata = BUS_W'(status_q);
`ifdef SUMHSQ_CAPTURE_IRQ_EN
            ADDR_IRQ_MASK: readdata = BUS_W'(irq_mask_q);
`else
            ADDR_IRQ_MASK: readdata = '0;
`endif
            ADDR_COUNT:    readdata = BUS_W'(count);
            default:       readdata = '0;
        endcase
    end

endmodule

// File: tb/tb_sumhsq_result_capture.sv
// Scoreboard bench for sumhsq_result_capture (DATA_W=24, CNT_W=4).
module tb_sumhsq_result_capture;

    localparam int unsigned DATA_W = 24;
    localparam int unsigned CNT_W  = 4;

`ifdef SUMHSQ_CAPTURE_IRQ_EN
    localparam bit IRQ_ON = 1'b1;
`else
    localparam bit IRQ_ON = 1'b0;
`endif

    typedef struct {
        string       name;
        bit          is_irq;
        logic [31:0] exp;
    } exp_t;

    logic              clk = 1'b0;
    logic              reset;
    logic [1:0]        address;
    logic              chipselect;
    logic              write_n;
    logic [31:0]       writedata;
    logic [31:0]       readdata;
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              irq;

    logic              chk_req = 1'b0;
    exp_t              sb[$];
    int                n_checks = 0;
    int                n_pass   = 0;

    always #5 clk = ~clk;

    sumhsq_result_capture #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .irq        (irq)
    );

    // Monitor: pops the next expectation whenever a check slot is presented
    always @(negedge clk) begin
        if (chk_req) begin
            exp_t e;
            logic [31:0] act;
            n_checks++;
            if (sb.size() == 0) begin
                $display("FAIL scoreboard_empty: check slot with no expectation");
            end else begin
                e   = sb.pop_front();
                act = e.is_irq ? {31'd0, irq} : readdata;
                if (act === e.exp) begin
                    n_pass++;
                end else begin
                    $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, act, e.exp);
                end
            end
        end
    end

    // Bus read with expected value queued for the monitor
    task automatic rd(input logic [1:0] a, input logic [31:0] e, input string nm);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b1;
        sb.push_back('{nm, 1'b0, e});
        chk_req    = 1'b1;
        @(posedge clk); #1;
        chipselect = 1'b0;
        chk_req    = 1'b0;
    endtask

    task automatic chk_irq(input logic e, input string nm);
        sb.push_back('{nm, 1'b1, {31'd0, e}});
        chk_req = 1'b1;
        @(posedge clk); #1;
        chk_req = 1'b0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(posedge clk); #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic strobe(input logic [DATA_W-1:0] d);
        in_data  = d;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Capture coincident with a register write
    task automatic strobe_wr(input logic [DATA_W-1:0] d, input logic [1:0] a, input logic [31:0] wd);
        in_data    = d;
        in_valid   = 1'b1;
        address    = a;
        writedata  = wd;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(posedge clk); #1;
        in_valid   = 1'b0;
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b1;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'd0;
        in_data    = '0;
        in_valid   = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        rd(2'd0, 32'h0, "rst_data");
        rd(2'd1, 32'h0, "rst_status");
        rd(2'd2, 32'h0, "rst_mask");
        rd(2'd3, 32'h0, "rst_count");
        chk_irq(1'b0, "rst_irq");

        strobe(24'hABCDEF);
        rd(2'd0, 32'h00ABCDEF, "cap_data");
        rd(2'd1, 32'h1, "cap_status");
        rd(2'd3, 32'h1, "cap_count");
        wr(2'd1, 32'h1);
        rd(2'd1, 32'h0, "w1c_new");

        wr(2'd3, 32'h0);
        strobe(24'h000111);
        strobe(24'h000222);
        rd(2'd0, 32'h00000222, "ovr_data");
        rd(2'd1, 32'h3, "ovr_status");
        rd(2'd3, 32'h2, "ovr_count");
        wr(2'd1, 32'h2);
        rd(2'd1, 32'h1, "w1c_ovr");

        strobe_wr(24'h000333, 2'd1, 32'h1);
        rd(2'd1, 32'h1, "cap_vs_clr_new");
        strobe_wr(24'h000444, 2'd3, 32'h0);
        rd(2'd3, 32'h1, "cap_vs_cnt_clr");
        rd(2'd0, 32'h00000444, "cap_vs_cnt_data");
        strobe_wr(24'h000555, 2'd1, 32'h2);
        rd(2'd1, 32'h3, "ovr_set_wins");
        wr(2'd1, 32'h3);
        rd(2'd1, 32'h0, "clr_both");

        wr(2'd3, 32'h0);
        for (int i = 1; i <= 15; i++) strobe(DATA_W'(i));
        rd(2'd3, 32'hF, "count_max");
        strobe(24'h00BEEF);
        rd(2'd3, 32'h0, "count_wrap");
        wr(2'd0, 32'hFFFFFFFF);
        rd(2'd0, 32'h0000BEEF, "data_ro");
        wr(2'd1, 32'hFFFFFFFC);
        rd(2'd1, 32'h3, "status_rsvd");
        wr(2'd1, 32'h3);

        wr(2'd2, 32'h1);
        rd(2'd2, IRQ_ON ? 32'h1 : 32'h0, "mask_rd");
        strobe(24'h000010);
        chk_irq(IRQ_ON, "irq_new");
        wr(2'd1, 32'h1);
        chk_irq(1'b0, "irq_new_clr");
        wr(2'd2, 32'h2);
        strobe(24'h000020);
        chk_irq(1'b0, "irq_ovr_first");
        strobe(24'h000030);
        chk_irq(IRQ_ON, "irq_ovr_second");
        wr(2'd1, 32'h3);
        chk_irq(1'b0, "irq_ovr_clr");

        strobe(24'h000040);
        in_valid = 1'b1;
        in_data  = 24'h000050;
        reset    = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        reset    = 1'b0;
        rd(2'd0, 32'h0, "mid_rst_data");
        rd(2'd1, 32'h0, "mid_rst_status");
        rd(2'd3, 32'h0, "mid_rst_count");
        rd(2'd2, 32'h0, "mid_rst_mask");

        repeat (2) @(posedge clk);
        if (sb.size() != 0) begin
            n_checks++;
            $display("FAIL scoreboard_leftover: %0d expectations not consumed", sb.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sumhsq_result_capture.md
# sumhsq_result_capture

Avalon-MM slave input port that returns a 24-bit sum-of-squares result from the ultrasonic processing fabric to the Nios II. It is the read-side counterpart of the SUMHSQ output PIO. A one-cycle `in_valid` strobe latches `in_data` into a holding register and sets a sticky new-data flag. Overrun detection, a capture counter and an optional interrupt let software poll or take an interrupt per result without missing events unknowingly.

## Interface
Parameters:
- DATA_W, 24, width of captured result; 1–32 legal; readdata zero-extended above DATA_W
- CNT_W, 16, width of capture counter; 1–32 legal

Ports:
- clk  in  1  system clock; single clock domain
- reset  in  1  synchronous, active-high reset
- address  in  2  register select
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe
- writedata  in  32  write data
- readdata  out  32  read data, combinational from address (zero wait states)
- in_data  in  DATA_W  result from processing chain, synchronous to clk
- in_valid  in  1  one-cycle strobe: in_data is valid this cycle
- irq  out  1  interrupt request, level, active-high (only with macro)

## Operation
- Register map (word addresses):
  - 0 DATA (RO): last captured value
  - 1 STATUS: bit0 NEW, bit1 OVR; write-1-to-clear per bit
  - 2 IRQ_MASK (RW): bit0 enables irq on NEW, bit1 enables irq on OVR
  - 3 COUNT (RO; any write clears to 0): captures since reset or clear, wraps 2^CNT_W−1 → 0
- Write = chipselect & ~write_n. Reads have no side effects.
- in_valid:
  - DATA ← in_data
  - NEW ← 1
  - COUNT ← COUNT+1
  - if NEW was already 1, OVR ← 1
  - Newest value always overwrites; no buffering.
- Simultaneous in_valid and STATUS write-1 to NEW: capture wins, NEW stays 1.
  - OVR is not set by that capture if the same write clears NEW. Clear-then-capture ordering.
- Simultaneous in_valid and W1C of OVR while NEW=1: OVR stays 1 (set wins).
- Simultaneous in_valid and COUNT write: COUNT ← 1.
- Writes to address 0, and to reserved bits, are ignored. Unused readdata bits read 0.
- irq = |(STATUS[1:0] & IRQ_MASK[1:0]).

## Timing
- Reset values: DATA=0, NEW=0, OVR=0, IRQ_MASK=0, COUNT=0, irq=0. readdata reflects these in the cycle after reset.
- in_valid sampled at edge N → DATA/STATUS/COUNT updated at edge N; visible on readdata and irq from cycle N+1.
- Register write at edge N takes effect from cycle N+1. readdata is combinational, so the CPU sees the new value on its next read.
- Back-to-back in_valid on every cycle is legal: each strobe is counted, and OVR sets on the second strobe.
- Reset asserted mid-operation overrides in_valid and writes in the same cycle.

## Configuration
- SUMHSQ_CAPTURE_IRQ_EN defined:
  - IRQ_MASK register and irq port are present, as above.
- Not defined:
  - irq port still exists, tied to 0.
  - Address 2 reads 0 and ignores writes.
  - No mask flops are synthesised.

## Structure
- Shared package holds:
  - register address constants ADDR_DATA/ADDR_STATUS/ADDR_IRQ_MASK/ADDR_COUNT
  - STATUS bit indices NEW_BIT/OVR_BIT
  - reset constants
- One sub-module is natural: sumhsq_capture_counter, a CNT_W wrap counter with sync clear and increment, clear-and-increment yielding 1.
- Register bank, flag logic and read mux remain in the top module.

## Test plan
- Reset, then read all four addresses → 0,0,0,0; irq=0.
- in_valid with in_data=0xABCDEF → next cycle DATA=0x00ABCDEF, STATUS=0x1, COUNT=1. Write 0x1 to STATUS → STATUS=0x0.
- Two strobes with 0x000111 then 0x000222 without clearing → DATA=0x000222, STATUS=0x3, COUNT=2. Write 0x2 → STATUS=0x1.
- Strobe in the same cycle as a write of 0x1 to STATUS with NEW=1 → STATUS=0x1, OVR stays 0. Strobe in the same cycle as a COUNT write → COUNT=1.
- Preload COUNT to 2^CNT_W−1 via 2^CNT_W−1 strobes (CNT_W=4 build) → one more strobe makes COUNT=0.
- With SUMHSQ_CAPTURE_IRQ_EN:
  - IRQ_MASK=0x1, one strobe → irq=1 next cycle; clear NEW → irq=0.
  - IRQ_MASK=0x2: one strobe leaves irq=0; a second strobe gives irq=1.
  - Without the macro, the same stimulus keeps irq=0 and address 2 reads 0.
